mxint_bias_accumulator: RTL and testbench

//  Streaming MXINT block accumulator with fused bias and runtime-programmable depth. Sits between
//  the mxint_dot_product array and mxint_cast in the linear datapath; replaces the separate

---
 rtl/mxint_acc_pkg.sv | 34 +++
 rtl/mxint_align_add.sv | 29 ++
 rtl/mxint_bias_accumulator.sv | 160 ++++++++++++++++
 tb/tb_mxint_bias_accumulator.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxint_acc_pkg.sv
// Shared types and helpers for the MXINT bias accumulator.
// Holds the FSM states, width helpers and the saturating arithmetic shift.
package mxint_acc_pkg;

    typedef enum logic [1:0] {
        S_FIRST,
        S_ACC,
        S_OUT
    } state_t;

    function automatic int acc_man_width(
        input int in_w,
        input int bias_w,
        input int max_depth
    );
        return ((in_w > bias_w) ? in_w : bias_w) + $clog2(max_depth) + 1;
    endfunction

    function automatic int depth_width(input int max_depth);
        return $clog2(max_depth + 1);
    endfunction

    // Shifting past the full width leaves only sign copies: 0 or -1.
    function automatic logic signed [63:0] sat_ashr(
        input logic signed [63:0] value,
        input logic [31:0]        amt
    );
        if (amt >= 32'd63) begin
            return {64{value[63]}};
        end
        return value >>> amt;
    endfunction

endpackage

// File: rtl/mxint_align_add.sv
// One accumulator lane: align either the running sum or the incoming
// mantissa to the larger exponent, then add.
module mxint_align_add
    import mxint_acc_pkg::*;
#(
    parameter int ACC_W = 21,
    parameter int SH_W  = 5
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] din,
    input  logic [SH_W-1:0]  amt,
    input  logic             shift_acc,
    output logic [ACC_W-1:0] sum
);

    logic signed [63:0] acc_x;
    logic signed [63:0] din_x;

    always_comb begin
        acc_x = {{(64-ACC_W){acc[ACC_W-1]}}, acc};
        din_x = {{(64-ACC_W){din[ACC_W-1]}}, din};
        if (shift_acc) begin
            sum = ACC_W'(sat_ashr(acc_x, 32'(amt))) + din;
        end else begin
            sum = acc + ACC_W'(sat_ashr(din_x, 32'(amt)));
        end
    end

endmodule

// File: rtl/mxint_bias_accumulator.sv
// Streaming MXINT block accumulator with optional bias seed and ReLU.
// Sums cfg_depth blocks with per-beat shared-exponent alignment.
module mxint_bias_accumulator
    import mxint_acc_pkg::*;
#(
    parameter int BLOCK_SIZE     = 4,
    parameter int IN_MAN_WIDTH   = 16,
    parameter int EXP_WIDTH      = 4,
    parameter int BIAS_MAN_WIDTH = 16,
    parameter int MAX_DEPTH      = 16,
    localparam int DEPTH_WIDTH   = depth_width(MAX_DEPTH),
    localparam int ACC_MAN_WIDTH =
        acc_man_width(IN_MAN_WIDTH, BIAS_MAN_WIDTH, MAX_DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic [DEPTH_WIDTH-1:0] cfg_depth,
    input  logic cfg_bias_en,
    input  logic cfg_relu,
    input  logic [BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0] mdata_in,
    input  logic [EXP_WIDTH-1:0] edata_in,
    input  logic data_in_valid,
    output logic data_in_ready,
    input  logic [BLOCK_SIZE-1:0][BIAS_MAN_WIDTH-1:0] mbias,
    input  logic [EXP_WIDTH-1:0] ebias,
    input  logic bias_valid,
    output logic bias_ready,
    output logic [BLOCK_SIZE-1:0][ACC_MAN_WIDTH-1:0] mdata_out,
    output logic [EXP_WIDTH-1:0] edata_out,
    output logic data_out_valid,
    input  logic data_out_ready
);

    localparam int DW = EXP_WIDTH + 1;

    state_t state;
    logic [DEPTH_WIDTH-1:0] count;
    logic [DEPTH_WIDTH-1:0] count_nx;
    logic [DEPTH_WIDTH-1:0] depth_q;
    logic [DEPTH_WIDTH-1:0] eff_depth;
    logic relu_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [EXP_WIDTH-1:0] exp_nx;
    logic [DW-1:0] ediff;
    logic [DW-1:0] amt;
    logic shift_acc;
    logic data_hs;
    logic bias_hs;

    logic [BLOCK_SIZE-1:0][ACC_MAN_WIDTH-1:0] acc;
    logic [BLOCK_SIZE-1:0][ACC_MAN_WIDTH-1:0] din_x;
    logic [BLOCK_SIZE-1:0][ACC_MAN_WIDTH-1:0] bias_x;
    logic [BLOCK_SIZE-1:0][ACC_MAN_WIDTH-1:0] sum;
    logic [BLOCK_SIZE-1:0][ACC_MAN_WIDTH-1:0] relu_sum;
    logic [BLOCK_SIZE-1:0][ACC_MAN_WIDTH-1:0] relu_first;

    always_comb begin
        bias_ready    = (state == S_FIRST) && cfg_bias_en;
        data_in_ready = (state == S_ACC) ||
                        ((state == S_FIRST) && !cfg_bias_en);
        bias_hs = bias_valid && bias_ready;
        data_hs = data_in_valid && data_in_ready;
        eff_depth = (cfg_depth == '0) ? DEPTH_WIDTH'(1) : cfg_depth;
        count_nx  = count + DEPTH_WIDTH'(1);
        // Sign-extended difference; positive means the sum must move.
        ediff = {edata_in[EXP_WIDTH-1], edata_in} -
                {exp_q[EXP_WIDTH-1], exp_q};
        shift_acc = !ediff[DW-1] && (ediff != '0);
        amt    = shift_acc ? ediff : -ediff;
        exp_nx = shift_acc ? edata_in : exp_q;
    end

    always_comb begin
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            din_x[i] = {{(ACC_MAN_WIDTH-IN_MAN_WIDTH)
                         {mdata_in[i][IN_MAN_WIDTH-1]}}, mdata_in[i]};
            bias_x[i] = {{(ACC_MAN_WIDTH-BIAS_MAN_WIDTH)
                          {mbias[i][BIAS_MAN_WIDTH-1]}}, mbias[i]};
            relu_sum[i] = (relu_q && sum[i][ACC_MAN_WIDTH-1]) ?
                          '0 : sum[i];
            relu_first[i] = (cfg_relu && din_x[i][ACC_MAN_WIDTH-1]) ?
                            '0 : din_x[i];
        end
    end

    for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_lane
        mxint_align_add #(
            .ACC_W (ACC_MAN_WIDTH),
            .SH_W  (DW)
        ) u_lane (
            .acc       (acc[g]),
            .din       (din_x[g]),
            .amt       (amt),
            .shift_acc (shift_acc),
            .sum       (sum[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_FIRST;
            count          <= '0;
            depth_q        <= '0;
            relu_q         <= 1'b0;
            acc            <= '0;
            exp_q          <= '0;
            mdata_out      <= '0;
            edata_out      <= '0;
            data_out_valid <= 1'b0;
        end else begin
            unique case (state)
                S_FIRST: begin
                    if (bias_hs) begin
                        acc     <= bias_x;
                        exp_q   <= ebias;
                        count   <= '0;
                        depth_q <= eff_depth;
                        relu_q  <= cfg_relu;
                        state   <= S_ACC;
                    end else if (data_hs) begin
                        acc     <= din_x;
                        exp_q   <= edata_in;
                        count   <= DEPTH_WIDTH'(1);
                        depth_q <= eff_depth;
                        relu_q  <= cfg_relu;
                        if (eff_depth == DEPTH_WIDTH'(1)) begin
                            mdata_out      <= relu_first;
                            edata_out      <= edata_in;
                            data_out_valid <= 1'b1;
                            state          <= S_OUT;
                        end else begin
                            state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (data_hs) begin
                        acc   <= sum;
                        exp_q <= exp_nx;
                        count <= count_nx;
                        if (count_nx == depth_q) begin
                            mdata_out      <= relu_sum;
                            edata_out      <= exp_nx;
                            data_out_valid <= 1'b1;
                            state          <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (data_out_ready) begin
                        data_out_valid <= 1'b0;
                        state          <= S_FIRST;
                    end
                end
                default: state <= S_FIRST;
            endcase
        end
    end

endmodule

// File: tb/tb_mxint_bias_accumulator.sv
// Directed-vector bench for mxint_bias_accumulator.
// Wider exponent so shift distances past the accumulator width are reachable.
module tb_mxint_bias_accumulator;

    localparam int BS = 4;
    localparam int IW = 16;
    localparam int EW = 6;
    localparam int BW = 16;
    localparam int MD = 16;
    localparam int DW = 5;
    localparam int AW = 21;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [DW-1:0] cfg_depth = '0;
    logic cfg_bias_en = 1'b0;
    logic cfg_relu = 1'b0;
    logic [BS-1:0][IW-1:0] mdata_in = '0;
    logic [EW-1:0] edata_in = '0;
    logic data_in_valid = 1'b0;
    logic data_in_ready;
    logic [BS-1:0][BW-1:0] mbias = '0;
    logic [EW-1:0] ebias = '0;
    logic bias_valid = 1'b0;
    logic bias_ready;
    logic [BS-1:0][AW-1:0] mdata_out;
    logic [EW-1:0] edata_out;
    logic data_out_valid;
    logic data_out_ready = 1'b0;

    int total = 0;
    int bad = 0;

    typedef logic [3:0][31:0] lane4_t;

    typedef struct {
        int     depth;
        bit     bias_en;
        bit     relu;
        lane4_t bm;
        int     be;
        int     nb;
        lane4_t d0;
        int     e0;
        lane4_t d1;
        int     e1;
        lane4_t d2;
        int     e2;
        lane4_t eo;
        int     ee;
    } vec_t;

    vec_t vt[11];

    mxint_bias_accumulator #(
        .BLOCK_SIZE     (BS),
        .IN_MAN_WIDTH   (IW),
        .EXP_WIDTH      (EW),
        .BIAS_MAN_WIDTH (BW),
        .MAX_DEPTH      (MD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_depth      (cfg_depth),
        .cfg_bias_en    (cfg_bias_en),
        .cfg_relu       (cfg_relu),
        .mdata_in       (mdata_in),
        .edata_in       (edata_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .mbias          (mbias),
        .ebias          (ebias),
        .bias_valid     (bias_valid),
        .bias_ready     (bias_ready),
        .mdata_out      (mdata_out),
        .edata_out      (edata_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic lane4_t L(input int a, input int b,
                                 input int c, input int d);
        lane4_t r;
        r[0] = a;
        r[1] = b;
        r[2] = c;
        r[3] = d;
        return r;
    endfunction

    function automatic vec_t mk(
        input int depth, input bit ben, input bit relu,
        input lane4_t bm, input int be, input int nb,
        input lane4_t d0, input int e0,
        input lane4_t d1, input int e1,
        input lane4_t d2, input int e2,
        input lane4_t eo, input int ee
    );
        vec_t v;
        v.depth = depth;
        v.bias_en = ben;
        v.relu = relu;
        v.bm = bm;
        v.be = be;
        v.nb = nb;
        v.d0 = d0;
        v.e0 = e0;
        v.d1 = d1;
        v.e1 = e1;
        v.d2 = d2;
        v.e2 = e2;
        v.eo = eo;
        v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic chk_out(input string nm, input lane4_t eo,
                           input int ee);
        for (int i = 0; i < BS; i++) begin
            chk($sformatf("%s lane%0d", nm, i),
                64'(mdata_out[i]), 64'(eo[i][AW-1:0]));
        end
        chk($sformatf("%s exp", nm), 64'(edata_out), 64'(ee[EW-1:0]));
    endtask

    task automatic wait_hs(input bit is_bias);
        int n;
        n = 0;
        @(negedge clk);
        while (!(is_bias ? bias_ready : data_in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL handshake timeout bias=%0d", is_bias);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_data(input lane4_t m, input int e);
        for (int i = 0; i < BS; i++) mdata_in[i] = m[i][IW-1:0];
        edata_in = e[EW-1:0];
        data_in_valid = 1'b1;
        wait_hs(1'b0);
        data_in_valid = 1'b0;
    endtask

    task automatic send_bias(input lane4_t m, input int e);
        for (int i = 0; i < BS; i++) mbias[i] = m[i][BW-1:0];
        ebias = e[EW-1:0];
        bias_valid = 1'b1;
        wait_hs(1'b1);
        bias_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
        chk($sformatf("%s drain", nm), 64'(data_out_valid), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        cfg_depth = v.depth[DW-1:0];
        cfg_bias_en = v.bias_en;
        cfg_relu = v.relu;
        if (v.bias_en) send_bias(v.bm, v.be);
        for (int b = 0; b < v.nb; b++) begin
            chk($sformatf("%s early valid", nm),
                64'(data_out_valid), 64'd0);
            if (b == 0) send_data(v.d0, v.e0);
            else if (b == 1) send_data(v.d1, v.e1);
            else send_data(v.d2, v.e2);
        end
        chk($sformatf("%s latency", nm), 64'(data_out_valid), 64'd1);
        chk_out(nm, v.eo, v.ee);
        drain(nm);
    endtask

    initial begin
        lane4_t z;
        z = L(0, 0, 0, 0);
        vt[0] = mk(1, 0, 0, z, 0, 1, L(3, -2, 0, 7), 1, z, 0, z, 0,
                   L(3, -2, 0, 7), 1);
        vt[1] = mk(3, 0, 0, z, 0, 3, L(5, 5, 5, 5), 0, L(5, 5, 5, 5), 0,
                   L(5, 5, 5, 5), 0, L(15, 15, 15, 15), 0);
        vt[2] = mk(2, 1, 0, L(8, 8, 8, 8), 2, 2, L(4, -4, 1, 0), 0,
                   L(4, -4, 1, 0), 0, z, 0, L(10, 6, 8, 8), 2);
        vt[3] = mk(2, 0, 0, z, 0, 2, L(16, -16, 8, 0), 0,
                   L(1, 1, 0, 0), 2, z, 0, L(5, -3, 2, 0), 2);
        vt[4] = mk(2, 0, 1, z, 0, 2, L(-3, 3, 0, 0), 0,
                   L(-1, 1, 0, 0), 0, z, 0, L(0, 4, 0, 0), 0);
        vt[5] = mk(2, 0, 0, z, 0, 2, L(-1, 1, -5, 0), 0,
                   L(0, 0, 0, 2), 21, z, 0, L(-1, 0, -1, 2), 21);
        vt[6] = mk(2, 0, 0, z, 0, 2, L(10, 0, 0, 0), 21,
                   L(-1, -100, 100, 5), 0, z, 0, L(9, -1, 0, 0), 21);
        vt[7] = mk(0, 0, 0, z, 0, 1, L(-7, 1, 2, 3), -3, z, 0, z, 0,
                   L(-7, 1, 2, 3), -3);
        vt[8] = mk(1, 1, 0, L(100, -50, 0, 1), -2, 1, L(4, 8, -8, 3), 0,
                   z, 0, z, 0, L(29, -5, -8, 3), 0);
        vt[9] = mk(1, 1, 1, L(-20, 20, 0, 0), 0, 1, L(5, 5, -1, 0), 1,
                   z, 0, z, 0, L(0, 15, 0, 0), 1);
        vt[10] = mk(3, 0, 0, z, 0, 3, L(-32768, -32768, 32767, 0), 0,
                    L(-32768, -32768, 32767, 0), 0,
                    L(-32768, -32768, 32767, 0), 0,
                    L(-98304, -98304, 98301, 0), 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst valid", 64'(data_out_valid), 64'd0);
        chk_out("rst", z, 0);
        chk("rst data_ready", 64'(data_in_ready), 64'd1);
        chk("rst bias_ready", 64'(bias_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 11; k++) run_vec(vt[k], k);

        // Backpressure: output held, no input accepted while stalled.
        cfg_depth = 5'd1;
        cfg_bias_en = 1'b0;
        cfg_relu = 1'b0;
        send_data(L(11, -12, 13, -14), 3);
        chk("bp latency", 64'(data_out_valid), 64'd1);
        for (int i = 0; i < BS; i++) mdata_in[i] = 16'd99;
        edata_in = '0;
        data_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("bp%0d", c), L(11, -12, 13, -14), 3);
            chk("bp valid", 64'(data_out_valid), 64'd1);
            chk("bp data_ready", 64'(data_in_ready), 64'd0);
            chk("bp bias_ready", 64'(bias_ready), 64'd0);
        end
        data_in_valid = 1'b0;
        drain("bp");

        // Config changes after the first beat must not take effect.
        cfg_depth = 5'd3;
        send_data(L(-5, 1, 1, 1), 0);
        cfg_depth = 5'd1;
        cfg_relu = 1'b1;
        send_data(L(-5, 1, 1, 1), 0);
        chk("cfg hold valid", 64'(data_out_valid), 64'd0);
        send_data(L(-5, 1, 1, 1), 0);
        chk("cfg hold latency", 64'(data_out_valid), 64'd1);
        chk_out("cfg hold", L(-15, 3, 3, 3), 0);
        drain("cfg hold");

        // Reset in the middle of an accumulation.
        cfg_depth = 5'd3;
        cfg_relu = 1'b0;
        send_data(L(50, 50, 50, 50), 4);
        send_data(L(50, 50, 50, 50), 4);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst valid", 64'(data_out_valid), 64'd0);
        chk_out("midrst", z, 0);
        chk("midrst data_ready", 64'(data_in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < BS; i++) mbias[i] = 16'd7;
        ebias = 6'd5;
        bias_valid = 1'b1;
        cfg_depth = 5'd2;
        #1;
        chk("stray bias_ready", 64'(bias_ready), 64'd0);
        send_data(L(1, 2, 3, 4), 0);
        send_data(L(1, 2, 3, 4), 0);
        bias_valid = 1'b0;
        chk("post rst latency", 64'(data_out_valid), 64'd1);
        chk_out("post rst", L(2, 4, 6, 8), 0);
        drain("post rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
